// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the multiply/divide unit decoder.
//   * funct codes of the R-type HI/LO instructions
//   * ALUOP_RTYPE: main-decoder ALU op that selects funct decoding
//   * state_e: engine sequencer states
//   * op_e: decoded MDU operation, plus decode/signedness helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  // Map aluop/funct to an MDU operation; anything unrecognised is OP_NONE.
  function automatic op_e decode_op(input logic [1:0] aluop, input logic [5:0] funct);
    op_e op;
    op = OP_NONE;
    if (aluop == ALUOP_RTYPE) begin
      case (funct)
        F_MULT:  op = OP_MULT;
        F_MULTU: op = OP_MULTU;
        F_DIV:   op = OP_DIV;
        F_DIVU:  op = OP_DIVU;
        F_MFHI:  op = OP_MFHI;
        F_MFLO:  op = OP_MFLO;
        F_MTHI:  op = OP_MTHI;
        F_MTLO:  op = OP_MTLO;
        default: op = OP_NONE;
      endcase
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  // Signed variants take operand magnitudes and need sign correction.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// -----------------------------------------------------------------------------
// mdu_iter_core -- one-bit-per-cycle unsigned multiply/divide datapath.
//   Multiply: shift-add, multiplier held in lo, multiplicand in opnd;
//             after WIDTH steps {hi,lo} is the unsigned product.
//   Divide:   restoring subtract, dividend held in lo, divisor in opnd;
//             after WIDTH steps lo is the quotient and hi the remainder.
//   Build option MDU_FAST_MUL_EN: prod_o is a single-cycle lo*opnd product
//   of the loaded operands instead of the iterated {hi,lo}.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   load_i            load operands, clear hi, counter := WIDTH
//   step_i, div_i     perform one iteration (divide when div_i, else multiply)
//   lo_init_i, opnd_i operand values captured on load_i
//   hi_o, lo_o        working registers
//   prod_o            2*WIDTH unsigned product
//   last_o            counter is at its final iteration
// -----------------------------------------------------------------------------
module mdu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   lo_init_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shf_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Next-state of the working registers and the iteration counter.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    sum_s  = {1'b0, hi_q} + {1'b0, opnd_q};
    // Divide: shift the next dividend bit into the partial remainder.
    shf_s  = {hi_q, lo_q[WIDTH-1]};
    ge_s   = (shf_s >= {1'b0, opnd_q});
    // When ge_s the true difference is below the divisor, so WIDTH bits suffice.
    diff_s = shf_s[WIDTH-1:0] - opnd_q;
    if (load_i) begin
      hi_d   = {WIDTH{1'b0}};
      lo_d   = lo_init_i;
      opnd_d = opnd_i;
      cnt_d  = CNT_W'(WIDTH);
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_i) begin
        hi_d = ge_s ? diff_s : shf_s[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ge_s};
      end else if (lo_q[0]) begin
        // Add multiplicand, then shift {carry,hi,lo} right one place.
        hi_d = sum_s[WIDTH:1];
        lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = {1'b0, hi_q[WIDTH-1:1]};
        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Working register and counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      opnd_q <= {WIDTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CNT_W'(1));

`ifdef MDU_FAST_MUL_EN
  assign prod_o = {{WIDTH{1'b0}}, lo_q} * {{WIDTH{1'b0}}, opnd_q};
`else
  assign prod_o = {hi_q, lo_q};
`endif

endmodule

// File: rtl/mdu_dec.sv
// -----------------------------------------------------------------------------
// mdu_dec -- HI/LO multiply/divide decoder and sequencer for the EX stage.
//   Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO (aluop==2'b10), runs the
//   iterative engine in mdu_iter_core, applies sign correction and owns HI/LO.
//   Build option MDU_FAST_MUL_EN: multiplies go IDLE -> FIX using a
//   single-cycle multiplier (busy one cycle); divide is unaffected.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   start         EX-stage instruction valid
//   aluop, funct  decode inputs
//   a, b          rs / rt operands
//   hi, lo        HI/LO registers
//   mdresult      MFHI/MFLO read data (combinational, 0 when not decoded)
//   busy          engine not IDLE
//   stall         MDU instruction presented while busy
//   done, dz      one-cycle completion pulse / divide-by-zero flag
// -----------------------------------------------------------------------------
module mdu_dec
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdresult,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  op_e    op_s;
  logic   mdop_s;
  logic   neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic   bz_q, bz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               sgn_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic               load_s, step_s;
  logic [WIDTH-1:0]   lo_init_s, opnd_s;
  logic [WIDTH-1:0]   core_hi_s, core_lo_s;
  logic [2*WIDTH-1:0] core_prod_s, prod_fix_s;
  logic               core_last_s;

  // Decode and operand magnitude preparation for signed ops.
  always_comb begin
    op_s    = decode_op(aluop, funct);
    mdop_s  = start && (op_s != OP_NONE);
    sgn_s   = op_is_signed(op_s);
    neg_a_s = sgn_s && a[WIDTH-1];
    neg_b_s = sgn_s && b[WIDTH-1];
    mag_a_s = neg_a_s ? -a : a;
    mag_b_s = neg_b_s ? -b : b;
  end

  // Sequencer next-state, engine control, sign fix and HI/LO updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    bz_d       = bz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    load_s     = 1'b0;
    step_s     = 1'b0;
    lo_init_s  = mag_a_s;
    opnd_s     = mag_b_s;
    prod_fix_s = core_prod_s;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_s)
            OP_MULT, OP_MULTU: begin
              load_s    = 1'b1;
              lo_init_s = mag_b_s;
              opnd_s    = mag_a_s;
              op_d      = op_s;
              neg_a_d   = neg_a_s;
              neg_b_d   = neg_b_s;
              bz_d      = 1'b0;
`ifdef MDU_FAST_MUL_EN
              state_d   = FIX;
`else
              state_d   = MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              load_s    = 1'b1;
              lo_init_s = mag_a_s;
              opnd_s    = mag_b_s;
              op_d      = op_s;
              neg_a_d   = neg_a_s;
              neg_b_d   = neg_b_s;
              bz_d      = (b == {WIDTH{1'b0}});
              state_d   = DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        step_s = 1'b1;
        if (core_last_s) begin
          state_d = FIX;
        end else begin
          state_d = state_q;
        end
      end
      FIX: begin
        state_d = IDLE;
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
          // Remainder follows the dividend; quotient sign is the xor of signs.
          hi_d = neg_a_q ? -core_hi_s : core_hi_s;
          if (bz_q) begin
            lo_d = {WIDTH{1'b1}};
          end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? -core_lo_s : core_lo_s;
          end
        end else begin
          prod_fix_s = (neg_a_q ^ neg_b_q) ? -core_prod_s : core_prod_s;
          hi_d       = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d       = prod_fix_s[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, latched op attributes and the architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mdu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (load_s),
    .step_i    (step_s),
    .div_i     (state_q == DIV),
    .lo_init_i (lo_init_s),
    .opnd_i    (opnd_s),
    .hi_o      (core_hi_s),
    .lo_o      (core_lo_s),
    .prod_o    (core_prod_s),
    .last_o    (core_last_s)
  );

  // MFHI/MFLO read path; zero whenever no read is decoded.
  always_comb begin
    if (mdop_s && (op_s == OP_MFHI)) begin
      mdresult = hi_q;
    end else if (mdop_s && (op_s == OP_MFLO)) begin
      mdresult = lo_q;
    end else begin
      mdresult = {WIDTH{1'b0}};
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = mdop_s && busy;
  assign done  = (state_q == FIX);
  assign dz    = (state_q == FIX) && bz_q;

endmodule
